// File: rtl/add64_seq_ctrl.sv
// Sequenced add/subtract unit: one shared SLICE_W-bit ripple adder stepped over
// NSLICE cycles, with a registered carry between slices.

module add16_ripple #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   always_comb begin
      logic [W:0] c;
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      end
      co = c[W];
   end

endmodule

module add64_seq_ctrl #(
   parameter int WIDTH   = 64,
   parameter int SLICE_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   // Handshake: start is taken on any edge where ready=1; done is a one-cycle
   // result-valid pulse and ready is also high during that cycle.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               c_out_q, c_out_d;
   logic               ovf_q, ovf_d;

   logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
   logic               sl_co;
   logic               last_slice;

   // Mux the active slice of the latched operands into the shared adder.
   always_comb begin
      sl_a = '0;
      sl_b = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (int'(cnt_q) == i) begin
            sl_a = a_q[i*SLICE_W +: SLICE_W];
            sl_b = b_q[i*SLICE_W +: SLICE_W];
         end
      end
   end

   add16_ripple #(
      .W (SLICE_W)
   ) u_slice (
      .a  (sl_a),
      .b  (sl_b),
      .ci (carry_q),
      .s  (sl_s),
      .co (sl_co)
   );

   assign last_slice = (int'(cnt_q) == NSLICE - 1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               // Subtract is folded into an add of ~b with carry-in 1.
               a_d     = a;
               b_d     = op_sub ? ~b : b;
               carry_d = op_sub ? 1'b1 : c_in;
               cnt_d   = '0;
               sum_d   = '0;
               c_out_d = 1'b0;
               ovf_d   = 1'b0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            for (int i = 0; i < NSLICE; i++) begin
               if (int'(cnt_q) == i) begin
                  sum_d[i*SLICE_W +: SLICE_W] = sl_s;
               end
            end
            carry_d = sl_co;
            if (last_slice) begin
               c_out_d = sl_co;
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (sl_s[SLICE_W-1] != a_q[WIDTH-1]);
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
   assign busy  = (state_q == S_RUN);
   assign done  = (state_q == S_DONE);
   assign sum   = sum_q;
   assign c_out = c_out_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_add64_seq_ctrl.sv
// Bench for add64_seq_ctrl: directed cases plus randomized ops against an
// arithmetic reference model with a result queue.

module tb_add64_seq_ctrl;

   localparam int NSLICE = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        op_sub;
   logic [63:0] a;
   logic [63:0] b;
   logic        c_in;
   logic        ready;
   logic        busy;
   logic        done;
   logic [63:0] sum;
   logic        c_out;
   logic        ovf;

   int          total = 0;
   int          bad   = 0;
   logic [65:0] exp_q[$];
   logic [65:0] last_exp = '0;

   add64_seq_ctrl dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op_sub (op_sub),
      .a      (a),
      .b      (b),
      .c_in   (c_in),
      .ready  (ready),
      .busy   (busy),
      .done   (done),
      .sum    (sum),
      .c_out  (c_out),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Reference: {ovf, c_out, sum} from wide integer arithmetic.
   function automatic logic [65:0] ref_calc(input logic [63:0] x, input logic [63:0] y,
                                            input logic sub, input logic ci);
      logic [64:0] u;
      logic [65:0] s;
      logic        co;
      if (sub) begin
         u  = {1'b0, x} - {1'b0, y};
         co = (x >= y);
         s  = {{2{x[63]}}, x} - {{2{y[63]}}, y};
      end else begin
         u  = {1'b0, x} + {1'b0, y} + {64'd0, ci};
         co = u[64];
         s  = {{2{x[63]}}, x} + {{2{y[63]}}, y} + {65'd0, ci};
      end
      return {(s[65:63] != 3'b000) && (s[65:63] != 3'b111), co, u[63:0]};
   endfunction

   task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v,
                         input logic ts, input logic tc, input bit disturb);
      logic [65:0] e;
      logic [63:0] mask;
      a      = ta;
      b      = tb_v;
      op_sub = ts;
      c_in   = tc;
      start  = 1'b1;
      exp_q.push_back(ref_calc(ta, tb_v, ts, tc));
      @(posedge clk);
      @(negedge clk);
      check("start_busy", busy, 1);
      check("start_ready", ready, 0);
      check("start_clear", sum, 0);
      e = exp_q[0];
      for (int k = 1; k <= NSLICE; k++) begin
         if (disturb) begin
            a      = {$urandom, $urandom};
            b      = {$urandom, $urandom};
            op_sub = 1'($urandom_range(0, 1));
            c_in   = 1'($urandom_range(0, 1));
            start  = 1'($urandom_range(0, 1));
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         mask = {64{1'b1}};
         mask = mask >> (64 - 16 * k);
         if (k < NSLICE) begin
            check("part_sum", sum, e[63:0] & mask);
            check("run_busy", busy, 1);
            check("run_done", done, 0);
         end else begin
            e        = exp_q.pop_front();
            last_exp = e;
            check("done", done, 1);
            check("ready", ready, 1);
            check("busy_off", busy, 0);
            check("sum", sum, e[63:0]);
            check("c_out", c_out, e[64]);
            check("ovf", ovf, e[65]);
         end
      end
      start = 1'b0;
   endtask

   task automatic idle_check(input int n);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("idle_done", done, 0);
         check("idle_ready", ready, 1);
         check("hold_sum", sum, last_exp[63:0]);
         check("hold_cout", c_out, last_exp[64]);
         check("hold_ovf", ovf, last_exp[65]);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b1;
      op_sub = 1'b0;
      c_in   = 1'b1;
      a      = {$urandom, $urandom};
      b      = {$urandom, $urandom};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         op_sub = 1'($urandom_range(0, 1));
         check("rst_sum", sum, 0);
         check("rst_cout", c_out, 0);
         check("rst_ovf", ovf, 0);
         check("rst_done", done, 0);
         check("rst_busy", busy, 0);
         check("rst_ready", ready, 1);
      end
      start = 1'b0;
      rst_n = 1'b1;
      idle_check(2);

      // Carry through every slice, then subtracts and signed overflow.
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0);
      idle_check(1);
      run_op(64'd5, 64'd7, 1'b1, 1'b1, 1'b0);
      idle_check(1);
      run_op(64'd7, 64'd5, 1'b1, 1'b0, 1'b0);
      idle_check(1);
      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0);
      idle_check(1);
      run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 1'b0);
      idle_check(1);

      // Disturbed inputs during RUN, then a start in the DONE cycle.
      run_op(64'h0001_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 1'b1);
      run_op(64'h1234, 64'h1234, 1'b0, 1'b1, 1'b0);
      idle_check(2);

      // Reset after the second RUN edge discards the op.
      a      = 64'hDEAD_BEEF_0000_FFFF;
      b      = 64'h1;
      op_sub = 1'b0;
      c_in   = 1'b0;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_sum", sum, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_ready", ready, 1);
      @(negedge clk);
      rst_n    = 1'b1;
      last_exp = '0;
      idle_check(5);
      run_op(64'd10, 64'd20, 1'b0, 1'b0, 1'b0);
      idle_check(1);

      // Randomized ops, with boundary-biased operands and back-to-back starts.
      for (int n = 0; n < 30; n++) begin
         logic [63:0] ra, rb;
         int          mode;
         mode = $urandom_range(0, 3);
         ra   = {$urandom, $urandom};
         rb   = {$urandom, $urandom};
         if (mode == 1) begin
            ra = 64'h7FFF_FFFF_FFFF_FFFF ^ {61'd0, 3'($urandom_range(0, 7))};
         end else if (mode == 2) begin
            ra = 64'h8000_0000_0000_0000 | {48'd0, 16'($urandom)};
            rb = {48'hFFFF_FFFF_FFFF, 16'($urandom)};
         end else if (mode == 3) begin
            ra = {4{16'hFFFF}} ^ {48'd0, 16'($urandom_range(0, 3))};
            rb = {60'd0, 4'($urandom_range(0, 15))};
         end
         run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) begin
            idle_check($urandom_range(1, 2));
         end
      end
      idle_check(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
